ctl_target_motion: RTL and testbench

- Parametrised motion controller for one on-screen target (duck) per game round.
- Spawns the target at a given x on the spawn line and moves it diagonally, reflecting off a configurable playfield box.
- Handles hit (pause, then fall) and timeout (fly away), and reports the round result.
- Sits between the round/game FSM (start, speeds, direction, shot result) and the sprite draw block (position, visibility, sprite select).

---
 rtl/ctl_target_motion.sv | 211 +++++++++++++++++++++
 tb/tb_ctl_target_motion.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ctl_target_motion.sv
// Motion controller for a single on-screen target per round: spawns on the
// floor line, flies diagonally inside a reflecting box, and handles hit
// (freeze, then fall) and timeout (fly off the top) before reporting the result.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start, sprite hidden
// FLY       | free flight with reflection, counting frames to timeout
// HIT_PAUSE | target frozen after a hit for HIT_FRAMES frames
// FALL      | target drops by FALL_SPD per frame until the floor
// ESCAPE    | target rises through the top edge, hits are still accepted
// DONE      | one-cycle result pulse, then back to IDLE
module ctl_target_motion #(
  parameter int POS_W      = 11,
  parameter int SPD_W      = 5,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 1024,
  parameter int Y_TOP      = 0,
  parameter int Y_FLOOR    = 600,
  parameter int DEF_V_SPD  = 15,
  parameter int FALL_SPD   = 8,
  parameter int FLY_FRAMES = 300,
  parameter int HIT_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_frame,
  input  logic             start,
  input  logic [POS_W-1:0] start_x,
  input  logic             start_dir,
  input  logic [SPD_W-1:0] h_spd,
  input  logic [SPD_W-1:0] v_spd,
  input  logic             shot_hit,
  output logic [POS_W-1:0] target_x,
  output logic [POS_W-1:0] target_y,
  output logic             target_show,
  output logic             target_hit,
  output logic             target_right,
  output logic             busy,
  output logic             result_valid,
  output logic             result_hit
);

  localparam int CNT_MAX = (FLY_FRAMES > HIT_FRAMES) ? FLY_FRAMES : HIT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FLY       = 3'd1;
  localparam logic [2:0] S_HIT_PAUSE = 3'd2;
  localparam logic [2:0] S_FALL      = 3'd3;
  localparam logic [2:0] S_ESCAPE    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  // Signed, one bit wider than a position, so steps past a bound never wrap.
  localparam logic signed [POS_W:0] XMIN_S   = (POS_W+1)'(X_MIN);
  localparam logic signed [POS_W:0] XMAX_S   = (POS_W+1)'(X_MAX);
  localparam logic signed [POS_W:0] YTOP_S   = (POS_W+1)'(Y_TOP);
  localparam logic signed [POS_W:0] YFLOOR_S = (POS_W+1)'(Y_FLOOR);
  localparam logic signed [POS_W:0] FALL_S   = (POS_W+1)'(FALL_SPD);

  localparam logic [CNT_W-1:0] FLY_LAST = CNT_W'(FLY_FRAMES - 1);
  localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_FRAMES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SPD_W-1:0] h_lat;
  logic [SPD_W-1:0] v_lat;
  logic             going_up;

  logic signed [POS_W:0] x_s, y_s, h_s, v_s, sx_s;
  logic signed [POS_W:0] x_step, y_step, y_fall;
  logic [POS_W-1:0]      fly_x, fly_y, spawn_x;
  logic                  fly_right, fly_up;

  // Next flight position with clamp-and-reflect on the playfield box.
  always_comb begin
    x_s    = $signed({1'b0, target_x});
    y_s    = $signed({1'b0, target_y});
    h_s    = $signed({{(POS_W+1-SPD_W){1'b0}}, h_lat});
    v_s    = $signed({{(POS_W+1-SPD_W){1'b0}}, v_lat});
    sx_s   = $signed({1'b0, start_x});
    x_step = target_right ? (x_s + h_s) : (x_s - h_s);
    y_step = going_up ? (y_s - v_s) : (y_s + v_s);
    y_fall = y_s + FALL_S;

    fly_x     = x_step[POS_W-1:0];
    fly_right = target_right;
    if (x_step < XMIN_S) begin
      fly_x     = XMIN_S[POS_W-1:0];
      fly_right = ~target_right;
    end else if (x_step > XMAX_S) begin
      fly_x     = XMAX_S[POS_W-1:0];
      fly_right = ~target_right;
    end

    fly_y  = y_step[POS_W-1:0];
    fly_up = going_up;
    if (y_step < YTOP_S) begin
      fly_y  = YTOP_S[POS_W-1:0];
      fly_up = ~going_up;
    end else if (y_step > YFLOOR_S) begin
      fly_y  = YFLOOR_S[POS_W-1:0];
      fly_up = ~going_up;
    end

    spawn_x = start_x;
    if (sx_s < XMIN_S)
      spawn_x = XMIN_S[POS_W-1:0];
    else if (sx_s > XMAX_S)
      spawn_x = XMAX_S[POS_W-1:0];
  end

  // Round sequencing, motion registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      h_lat        <= '0;
      v_lat        <= '0;
      going_up     <= 1'b0;
      target_x     <= '0;
      target_y     <= '0;
      target_show  <= 1'b0;
      target_hit   <= 1'b0;
      target_right <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FLY;
            cnt          <= '0;
            h_lat        <= h_spd;
            v_lat        <= (v_spd == '0) ? SPD_W'(DEF_V_SPD) : v_spd;
            going_up     <= 1'b1;
            target_x     <= spawn_x;
            target_y     <= YFLOOR_S[POS_W-1:0];
            target_right <= start_dir;
            target_show  <= 1'b1;
            target_hit   <= 1'b0;
            busy         <= 1'b1;
            result_hit   <= 1'b0;
          end
        end
        S_FLY: begin
          if (shot_hit) begin
            state      <= S_HIT_PAUSE;
            target_hit <= 1'b1;
            cnt        <= '0;
          end else if (new_frame) begin
            target_x     <= fly_x;
            target_y     <= fly_y;
            target_right <= fly_right;
            going_up     <= fly_up;
            cnt          <= cnt + CNT_W'(1);
            if (cnt == FLY_LAST)
              state <= S_ESCAPE;
          end
        end
        S_ESCAPE: begin
          if (shot_hit) begin
            state      <= S_HIT_PAUSE;
            target_hit <= 1'b1;
            cnt        <= '0;
          end else if (new_frame) begin
            if (target_y < POS_W'(v_lat)) begin
              target_y     <= '0;
              state        <= S_DONE;
              result_valid <= 1'b1;
              result_hit   <= 1'b0;
              target_show  <= 1'b0;
              busy         <= 1'b0;
            end else begin
              target_y <= target_y - POS_W'(v_lat);
            end
          end
        end
        S_HIT_PAUSE: begin
          if (new_frame) begin
            if (cnt == HIT_LAST) begin
              state <= S_FALL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_FALL: begin
          if (new_frame) begin
            if (y_fall >= YFLOOR_S) begin
              target_y     <= YFLOOR_S[POS_W-1:0];
              state        <= S_DONE;
              result_valid <= 1'b1;
              result_hit   <= 1'b1;
              target_show  <= 1'b0;
              busy         <= 1'b0;
            end else begin
              target_y <= y_fall[POS_W-1:0];
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_target_motion.sv
// Directed bench for ctl_target_motion: launch, reflection, timeout, hit/fall
// and ignored events, with hand-computed expectations.
module tb_ctl_target_motion;

  logic        clk;
  logic        rst;
  logic        new_frame;
  logic        start;
  logic [10:0] start_x;
  logic        start_dir;
  logic [4:0]  h_spd;
  logic [4:0]  v_spd;
  logic        shot_hit;
  logic [10:0] target_x;
  logic [10:0] target_y;
  logic        target_show;
  logic        target_hit;
  logic        target_right;
  logic        busy;
  logic        result_valid;
  logic        result_hit;

  int pass_cnt = 0;
  int total    = 0;

  ctl_target_motion dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
    .start_x(start_x), .start_dir(start_dir), .h_spd(h_spd), .v_spd(v_spd),
    .shot_hit(shot_hit), .target_x(target_x), .target_y(target_y),
    .target_show(target_show), .target_hit(target_hit),
    .target_right(target_right), .busy(busy), .result_valid(result_valid),
    .result_hit(result_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) new_frame = 1'b1;
      @(negedge clk) new_frame = 1'b0;
    end
  endtask

  task automatic launch(input logic [10:0] sx, input logic dir, input logic [4:0] h, input logic [4:0] v);
    @(negedge clk);
    start = 1'b1; start_x = sx; start_dir = dir; h_spd = h; v_spd = v;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; start = 1'b0; start_x = '0;
    start_dir = 1'b0; h_spd = '0; v_spd = '0; shot_hit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_x", target_x, 0);
    chk("rst_y", target_y, 0);
    chk("rst_show", target_show, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_rh", result_hit, 0);

    // shot in IDLE is ignored
    @(negedge clk) shot_hit = 1'b1;
    @(negedge clk) shot_hit = 1'b0;
    chk("idle_shot_hit", target_hit, 0);
    chk("idle_shot_busy", busy, 0);

    // launch with default vertical speed
    launch(11'd100, 1'b1, 5'd4, 5'd0);
    chk("launch_x", target_x, 100);
    chk("launch_y", target_y, 600);
    chk("launch_right", target_right, 1);
    chk("launch_busy", busy, 1);
    chk("launch_show", target_show, 1);
    frames(1);
    chk("f1_x", target_x, 104);
    chk("f1_y", target_y, 585);

    // start while busy is ignored
    launch(11'd5, 1'b0, 5'd9, 5'd9);
    chk("busy_start_x", target_x, 104);
    chk("busy_start_right", target_right, 1);
    frames(1);
    chk("f2_x", target_x, 108);
    chk("f2_y", target_y, 570);

    // reset mid-flight
    reset_pulse();
    chk("midrst_x", target_x, 0);
    chk("midrst_y", target_y, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_show", target_show, 0);
    chk("midrst_right", target_right, 0);

    // start_x above X_MAX is clamped
    launch(11'd2000, 1'b0, 5'd3, 5'd5);
    chk("clamp_x", target_x, 1024);
    chk("clamp_busy", busy, 1);
    frames(1);
    chk("clamp_f1_x", target_x, 1021);
    chk("clamp_f1_y", target_y, 595);

    // corner reflection: x and y both leave the box on frame 41
    reset_pulse();
    launch(11'd700, 1'b1, 5'd8, 5'd15);
    frames(40);
    chk("corner_f40_x", target_x, 1020);
    chk("corner_f40_y", target_y, 0);
    frames(1);
    chk("corner_f41_x", target_x, 1024);
    chk("corner_f41_y", target_y, 0);
    chk("corner_f41_right", target_right, 0);
    frames(1);
    chk("corner_f42_x", target_x, 1016);
    chk("corner_f42_y", target_y, 15);

    // timeout: vertical-only flight, then escape
    reset_pulse();
    launch(11'd500, 1'b0, 5'd0, 5'd0);
    frames(299);
    chk("to_f299_y", target_y, 180);
    chk("to_f299_x", target_x, 500);
    frames(1);
    chk("to_f300_y", target_y, 195);
    frames(1);
    chk("esc_f1_y", target_y, 180);
    frames(12);
    chk("esc_f13_y", target_y, 0);
    chk("esc_f13_busy", busy, 1);
    chk("esc_f13_rv", result_valid, 0);
    frames(1);
    chk("esc_done_rv", result_valid, 1);
    chk("esc_done_rh", result_hit, 0);
    chk("esc_done_busy", busy, 0);
    chk("esc_done_show", target_show, 0);
    @(negedge clk);
    chk("esc_after_rv", result_valid, 0);

    // hit coinciding with new_frame at (500, 300)
    launch(11'd500, 1'b1, 5'd0, 5'd0);
    frames(20);
    chk("hit_pre_y", target_y, 300);
    @(negedge clk) begin shot_hit = 1'b1; new_frame = 1'b1; end
    @(negedge clk) begin shot_hit = 1'b0; new_frame = 1'b0; end
    chk("hit_x", target_x, 500);
    chk("hit_y", target_y, 300);
    chk("hit_flag", target_hit, 1);
    @(negedge clk) shot_hit = 1'b1;
    @(negedge clk) shot_hit = 1'b0;
    chk("pause_shot_y", target_y, 300);
    frames(29);
    chk("pause29_y", target_y, 300);
    frames(1);
    chk("pause30_y", target_y, 300);
    frames(1);
    chk("fall1_y", target_y, 308);
    frames(36);
    chk("fall37_y", target_y, 596);
    chk("fall37_hit", target_hit, 1);
    chk("fall37_busy", busy, 1);
    frames(1);
    chk("fall_done_y", target_y, 600);
    chk("fall_done_rv", result_valid, 1);
    chk("fall_done_rh", result_hit, 1);
    chk("fall_done_busy", busy, 0);
    @(negedge clk);
    chk("fall_after_rv", result_valid, 0);
    chk("fall_after_rh", result_hit, 1);
    chk("fall_after_y", target_y, 600);

    // next round starts normally and clears the result
    launch(11'd10, 1'b1, 5'd1, 5'd1);
    chk("next_x", target_x, 10);
    chk("next_rh", result_hit, 0);
    chk("next_busy", busy, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
